rename_regfile_mp: RTL
======================

Name: rename_regfile_mp

Overview:
- Multi-port architectural register file with rename tags, for a superscalar front end.
- Holds committed values plus an "owning ROB tag" per register; tag 0 means the value is final.
- Sits between decoder/dispatch (rename writes, operand reads) and ROB (commit writes, flush).
- Generalises the single-issue tagged file to ISSUE_W rename slots, COMMIT_W commit ports, intra-group dependency forwarding and a live pending-register count.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, register count; register 0 is hardwired zero.
- REG_W, 5, register index width (clog2 NUM_REGS).
- TAG_W, 5, ROB tag width; tag 0 is reserved as "none".
- ISSUE_W, 2, rename slots per cycle; each slot has rs1/rs2 read ports.
- COMMIT_W, 2, commit ports per cycle; a higher index is younger in program order.

Ports:
- clk  in  1  clock.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  mispredict flush.
- ren_en  in  ISSUE_W  rename slot valid.
- ren_rd  in  ISSUE_W*REG_W  destination register per slot.
- ren_tag  in  ISSUE_W*TAG_W  ROB tag allocated per slot.
- rd_rs1, rd_rs2  in  ISSUE_W*REG_W  source registers per slot.
- rs1_val, rs2_val  out  ISSUE_W*XLEN  operand values.
- rs1_tag, rs2_tag  out  ISSUE_W*TAG_W  pending tag per operand; 0 = ready.
- cm_en  in  COMMIT_W  commit valid.
- cm_rd  in  COMMIT_W*REG_W  commit destination.
- cm_tag  in  COMMIT_W*TAG_W  committing ROB tag.
- cm_val  in  COMMIT_W*XLEN  committed result.
- pending_cnt  out  REG_W+1  registered count of registers with nonzero tag.

Behaviour:
- Reset (rst_in low, async): all values 0, all tags 0, pending_cnt 0. Outputs then reflect the zeroed array.
- rdy_in low: no array or counter update. Combinational reads still valid.
- State updates occur on posedge clk when rdy_in is high. Order of effects within a cycle:
  - Commits: for each cm_en[k] with cm_rd != 0, value <= cm_val. The tag is cleared to 0 only if the stored tag == cm_tag[k].
  - Same rd on two commit ports: the higher index wins for both value and tag-clear check.
  - Renames (ignored when flush): for each ren_en[j] with ren_rd != 0, tag <= ren_tag[j]. Same rd on two slots: the higher index wins.
  - A rename beats a commit tag-clear to the same register in the same cycle. The commit's value is still written.
  - flush: all tags <= 0 and all renames are dropped. Commits in the flush cycle still write values.
- Writes to register 0 are discarded. Reads of register 0 always return val 0, tag 0.
- Reads are combinational, zero latency. Per operand of slot j, priority from highest to lowest:
  - a) The youngest rename in slots 0..j-1 of the same cycle with matching rd and ren_en set: return that ren_tag. Val is don't-care.
  - b) A commit this cycle to that rd whose cm_tag equals the stored tag: return tag 0 and the youngest such cm_val. Under flush, b still applies.
  - c) Stored tag and value.
- A slot's own rename never affects its own sources (e.g. add x5,x5,x1 reads the old x5).
- pending_cnt: updated on the same edge to equal the population count of nonzero tags after the update. Flush gives 0. Range 0..NUM_REGS-1.

Optional Feature:
- RF_BYPASS_EN.
- Defined: read priority rule b is active (commit-to-read bypass in the same cycle).
- Undefined: rule b is removed. Reads see the stored tag until the edge after commit, one cycle later. This saves the comparator mux.
- Rule a is always present.

Test Plan:
- Reset: drive rst_in low mid-cycle with tags set → pending_cnt=0 immediately; rs1_tag=0 and rs1_val=0 for all registers.
- Rename x5 tag 3 (slot 0), next cycle commit x5 tag 3 val 0x1234 → the following cycle x5 reads tag 0, val 0x1234; pending_cnt goes 1→0.
- Stale commit: x5 tag 7 is current, commit x5 tag 3 val 0xAA → value=0xAA, tag stays 7, pending_cnt unchanged.
- Intra-group: slot0 renames x6 tag 4, slot1 reads rs1=x6 in the same cycle → rs1_tag[1]=4. Slot0 rs1=x6 shows the old tag 0.
- Bypass: x7 tag 2 pending, commit x7 tag 2 val 0x55 and read x7 in the same cycle → tag 0, val 0x55 with RF_BYPASS_EN; tag 2 without it.
- Flush with rename x8 tag 9 and commit x9 val 0x11 in the same cycle → all tags 0, x8 not renamed, x9=0x11, pending_cnt=0; with rdy_in low nothing changes.

Source files
------------

// File: rtl/rename_regfile_mp_if.sv
// rtl/rename_regfile_mp_if.sv - rename/read/commit bundle between dispatch+ROB and the tagged register file
interface rename_regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 5,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2
);
  logic                        flush;
  logic [ISSUE_W-1:0]          ren_en;
  logic [ISSUE_W*REG_W-1:0]    ren_rd;
  logic [ISSUE_W*TAG_W-1:0]    ren_tag;
  logic [ISSUE_W*REG_W-1:0]    rd_rs1;
  logic [ISSUE_W*REG_W-1:0]    rd_rs2;
  logic [ISSUE_W*XLEN-1:0]     rs1_val;
  logic [ISSUE_W*XLEN-1:0]     rs2_val;
  logic [ISSUE_W*TAG_W-1:0]    rs1_tag;
  logic [ISSUE_W*TAG_W-1:0]    rs2_tag;
  logic [COMMIT_W-1:0]         cm_en;
  logic [COMMIT_W*REG_W-1:0]   cm_rd;
  logic [COMMIT_W*TAG_W-1:0]   cm_tag;
  logic [COMMIT_W*XLEN-1:0]    cm_val;
  logic [REG_W:0]              pending_cnt;

  // dispatch/ROB side
  modport master (
    output flush, ren_en, ren_rd, ren_tag, rd_rs1, rd_rs2, cm_en, cm_rd, cm_tag, cm_val,
    input  rs1_val, rs2_val, rs1_tag, rs2_tag, pending_cnt
  );

  // register file side
  modport slave (
    input  flush, ren_en, ren_rd, ren_tag, rd_rs1, rd_rs2, cm_en, cm_rd, cm_tag, cm_val,
    output rs1_val, rs2_val, rs1_tag, rs2_tag, pending_cnt
  );
endinterface

// File: rtl/rename_regfile_mp.sv
// rtl/rename_regfile_mp.sv - multi-port architectural register file with ROB rename tags (optional RF_BYPASS_EN)
module rename_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int TAG_W    = 5,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2
) (
  input  logic clk,
  input  logic rst_in,
  input  logic rdy_in,
  rename_regfile_mp_if.slave bus
);

  logic [XLEN-1:0]  val_q [NUM_REGS];
  logic [XLEN-1:0]  val_d [NUM_REGS];
  logic [TAG_W-1:0] tag_q [NUM_REGS];
  logic [TAG_W-1:0] tag_d [NUM_REGS];
  logic [REG_W:0]   cnt_q;
  logic [REG_W:0]   cnt_d;
  logic [NUM_REGS-1:0] clr;

  // read results indexed [operand][slot]; operand 0 = rs1, 1 = rs2
  logic [XLEN-1:0]  op_val [2][ISSUE_W];
  logic [TAG_W-1:0] op_tag [2][ISSUE_W];

  // next state: commits write values (youngest port wins), renames override any tag clear, flush wipes tags
  always_comb begin
    logic [REG_W-1:0] rd;
    val_d = val_q;
    tag_d = tag_q;
    clr   = '0;
    cnt_d = '0;
    rd    = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      rd = bus.cm_rd[k*REG_W +: REG_W];
      if (bus.cm_en[k] && rd != '0) begin
        val_d[rd] = bus.cm_val[k*XLEN +: XLEN];
        // overwritten by a younger port to the same rd, so only its tag is checked
        clr[rd]   = (tag_q[rd] == bus.cm_tag[k*TAG_W +: TAG_W]);
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (clr[r]) tag_d[r] = '0;
    end
    if (bus.flush) begin
      for (int r = 0; r < NUM_REGS; r++) tag_d[r] = '0;
    end else begin
      for (int j = 0; j < ISSUE_W; j++) begin
        rd = bus.ren_rd[j*REG_W +: REG_W];
        if (bus.ren_en[j] && rd != '0) tag_d[rd] = bus.ren_tag[j*TAG_W +: TAG_W];
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (tag_d[r] != '0) cnt_d = cnt_d + {{REG_W{1'b0}}, 1'b1};
    end
  end

  // state registers, frozen while rdy_in is low
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      cnt_q <= '0;
    end else if (rdy_in) begin
      val_q <= val_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  // operand reads: older same-group rename beats same-cycle commit bypass beats stored state
  always_comb begin
    logic [REG_W-1:0] src;
    logic [XLEN-1:0]  ov;
    logic [TAG_W-1:0] ot;
    src = '0;
    ov  = '0;
    ot  = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int op = 0; op < 2; op++) begin
        src = (op == 0) ? bus.rd_rs1[j*REG_W +: REG_W] : bus.rd_rs2[j*REG_W +: REG_W];
        ov  = val_q[src];
        ot  = tag_q[src];
`ifdef RF_BYPASS_EN
        for (int k = 0; k < COMMIT_W; k++) begin
          if (bus.cm_en[k] && bus.cm_rd[k*REG_W +: REG_W] == src &&
              bus.cm_tag[k*TAG_W +: TAG_W] == tag_q[src]) begin
            ot = '0;
            ov = bus.cm_val[k*XLEN +: XLEN];
          end
        end
`endif
        // only strictly older slots; a slot never sees its own rename
        for (int i = 0; i < j; i++) begin
          if (bus.ren_en[i] && bus.ren_rd[i*REG_W +: REG_W] == src) begin
            ot = bus.ren_tag[i*TAG_W +: TAG_W];
          end
        end
        if (src == '0) begin
          ov = '0;
          ot = '0;
        end
        op_val[op][j] = ov;
        op_tag[op][j] = ot;
      end
    end
  end

  for (genvar j = 0; j < ISSUE_W; j++) begin : g_out
    assign bus.rs1_val[j*XLEN +: XLEN]   = op_val[0][j];
    assign bus.rs2_val[j*XLEN +: XLEN]   = op_val[1][j];
    assign bus.rs1_tag[j*TAG_W +: TAG_W] = op_tag[0][j];
    assign bus.rs2_tag[j*TAG_W +: TAG_W] = op_tag[1][j];
  end

  assign bus.pending_cnt = cnt_q;

endmodule
